// File: rtl/switch_pkg.sv
// Shared types and constants for the NoC input-port switch.
package switch_pkg;

  localparam int unsigned DEF_WORD_WIDTH = 32;
  localparam int unsigned OUTPORTS       = 4;
  localparam int unsigned SEL_W          = 2;

  // Flit field offsets (x/y/loc are only meaningful in header flits)
  localparam int unsigned TYPE_LSB = 0;
  localparam int unsigned LOC_LSB  = 2;
  localparam int unsigned Y_LSB    = 5;
  localparam int unsigned X_LSB    = 9;

  // 2'b11 is reserved and treated as a body flit
  typedef enum logic [1:0] {
    BODY = 2'b00,
    HEAD = 2'b01,
    TAIL = 2'b10
  } flit_type_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    WAIT_TAIL = 2'd2
  } state_e;

endpackage

// File: rtl/top_module_switch_sync2.sv
// Parameterised-width two-flop synchronizer for the asynchronous handshake inputs.
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two-stage capture; reset clears both stages
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/top_module_switch.sv
// NoC input-port switch: one upstream 2-phase channel steered to 4 downstream
// 2-phase channels with wormhole (header/body/tail) packet grants.
// Optional macro SYNC_INPUTS_EN: synchronize req_up_i, ack_dw_i and
// Tailpassed_dw_i through two flops before use.
module top_module_switch
  import switch_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  gen_enable,
  input  logic                  req_up_i,
  input  logic [WORD_WIDTH-1:0] Data_up_i,
  output logic                  ack_up_o,
  output logic [OUTPORTS-1:0]   req_dw_o,
  output logic [WORD_WIDTH-1:0] Data_dw0_o,
  output logic [WORD_WIDTH-1:0] Data_dw1_o,
  output logic [WORD_WIDTH-1:0] Data_dw2_o,
  output logic [WORD_WIDTH-1:0] Data_dw3_o,
  input  logic [OUTPORTS-1:0]   ack_dw_i,
  input  logic [OUTPORTS-1:0]   Tailpassed_dw_i,
  output logic [OUTPORTS-1:0]   PacketEnable_dw_o
);

  localparam int unsigned SYNC_W = 1 + 2 * OUTPORTS;

  state_e                state, state_next;
  logic [WORD_WIDTH-1:0] flit;
  logic [WORD_WIDTH-1:0] dw_data;
  logic                  full;
  logic                  sent;
  logic [SEL_W-1:0]      sel;
  logic [15:0]           drop_cnt;

  logic                  req_s;
  logic [OUTPORTS-1:0]   ack_s;
  logic [OUTPORTS-1:0]   tail_s;

  logic                  cap_c;
  logic                  hs_match_c;
  logic                  is_head_c;
  logic                  is_tail_c;
  logic                  grant_c;
  logic                  drop_c;
  logic                  send_c;
  logic                  done_c;
  logic                  release_c;

`ifdef SYNC_INPUTS_EN
  sync2 #(
    .WIDTH (SYNC_W)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     ({req_up_i, ack_dw_i, Tailpassed_dw_i}),
    .q     ({req_s, ack_s, tail_s})
  );
`else
  assign req_s  = req_up_i;
  assign ack_s  = ack_dw_i;
  assign tail_s = Tailpassed_dw_i;
`endif

  assign is_head_c  = (flit[TYPE_LSB +: 2] == HEAD);
  assign is_tail_c  = (flit[TYPE_LSB +: 2] == TAIL);
  assign hs_match_c = (req_dw_o[sel] == ack_s[sel]);

  // Capture only from a previously empty buffer; the tail wait blocks new flits
  assign cap_c = (req_s != ack_up_o) && !full && gen_enable && (state != WAIT_TAIL);

  // All downstream ports see the same flit register
  assign Data_dw0_o = dw_data;
  assign Data_dw1_o = dw_data;
  assign Data_dw2_o = dw_data;
  assign Data_dw3_o = dw_data;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (full && is_head_c) state_next = STREAM;
      STREAM:    if (full && sent && hs_match_c && is_tail_c) state_next = WAIT_TAIL;
      WAIT_TAIL: if (tail_s[sel]) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Per-state action strobes for the datapath
  always_comb begin
    grant_c   = 1'b0;
    drop_c    = 1'b0;
    send_c    = 1'b0;
    done_c    = 1'b0;
    release_c = 1'b0;
    case (state)
      IDLE: begin
        if (full) begin
          if (is_head_c) grant_c = 1'b1;
          else           drop_c  = 1'b1;
        end
      end
      STREAM: begin
        if (full && hs_match_c) begin
          if (sent) done_c = 1'b1;
          else      send_c = 1'b1;
        end
      end
      WAIT_TAIL: release_c = tail_s[sel];
      default: ;
    endcase
  end

  // Flit buffer, downstream handshake and grant registers
  always_ff @(posedge clk) begin
    if (reset) begin
      flit              <= '0;
      full              <= 1'b0;
      sent              <= 1'b0;
      ack_up_o          <= 1'b0;
      req_dw_o          <= '0;
      dw_data           <= '0;
      sel               <= '0;
      PacketEnable_dw_o <= '0;
      drop_cnt          <= '0;
    end else begin
      if (cap_c) begin
        flit     <= Data_up_i;
        full     <= 1'b1;
        ack_up_o <= req_s;
      end
      if (drop_c) begin
        full     <= 1'b0;
        drop_cnt <= drop_cnt + 16'(1);
      end
      if (grant_c) begin
        sel               <= flit[LOC_LSB +: SEL_W];
        PacketEnable_dw_o <= OUTPORTS'(1) << flit[LOC_LSB +: SEL_W];
      end
      if (send_c) begin
        dw_data       <= flit;
        req_dw_o[sel] <= ~req_dw_o[sel];
        sent          <= 1'b1;
      end
      if (done_c) begin
        full <= 1'b0;
        sent <= 1'b0;
      end
      if (release_c) begin
        PacketEnable_dw_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_top_module_switch.sv
// Self-checking bench for top_module_switch: directed scenarios plus randomized
// packets checked against a packet-level routing model.
module tb_top_module_switch;
  import switch_pkg::*;

  localparam int unsigned W = 32;
  typedef logic [W-1:0] fq_t[$];

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         gen_enable = 1'b1;
  logic         req_up_i = 1'b0;
  logic [W-1:0] Data_up_i = '0;
  logic         ack_up_o;
  logic [3:0]   req_dw_o;
  logic [W-1:0] Data_dw0_o, Data_dw1_o, Data_dw2_o, Data_dw3_o;
  logic [3:0]   ack_dw_i = '0;
  logic [3:0]   Tailpassed_dw_i;
  logic [3:0]   PacketEnable_dw_o;
  logic [3:0]   tp_resp = '0;
  logic [3:0]   tp_force = '0;
  logic [W-1:0] data_dw [4];

  int checks = 0;
  int errors = 0;

  // Responder controls and records
  bit    ack_en = 1'b1;
  int    max_dly = 0;
  bit    tp_clear = 1'b1;
  fq_t   rx_q [4];
  int    mon_err = 0;
  int    pe_hits [4] = '{0, 0, 0, 0};

  // Reference model state
  fq_t   exp_q [4];
  bit    m_in_pkt = 1'b0;
  int    m_port = 0;
  int    chk_base [4] = '{0, 0, 0, 0};
  int    pe_base [4] = '{0, 0, 0, 0};
  int    mon_base = 0;

  always #5 clk = ~clk;

  assign Tailpassed_dw_i = tp_resp | tp_force;
  assign data_dw[0] = Data_dw0_o;
  assign data_dw[1] = Data_dw1_o;
  assign data_dw[2] = Data_dw2_o;
  assign data_dw[3] = Data_dw3_o;

  top_module_switch dut (
    .clk               (clk),
    .reset             (reset),
    .gen_enable        (gen_enable),
    .req_up_i          (req_up_i),
    .Data_up_i         (Data_up_i),
    .ack_up_o          (ack_up_o),
    .req_dw_o          (req_dw_o),
    .Data_dw0_o        (Data_dw0_o),
    .Data_dw1_o        (Data_dw1_o),
    .Data_dw2_o        (Data_dw2_o),
    .Data_dw3_o        (Data_dw3_o),
    .ack_dw_i          (ack_dw_i),
    .Tailpassed_dw_i   (Tailpassed_dw_i),
    .PacketEnable_dw_o (PacketEnable_dw_o)
  );

  // Wormhole routing model: a header opens a packet on port loc[1:0], every flit
  // up to and including the tail follows it, anything outside a packet is dropped.
  function automatic void model_flit(input logic [W-1:0] f);
    logic [1:0] t;
    t = f[1:0];
    if (!m_in_pkt) begin
      if (t == 2'b01) begin
        m_port   = int'(f[3:2]);
        m_in_pkt = 1'b1;
        exp_q[m_port].push_back(f);
      end
    end else begin
      exp_q[m_port].push_back(f);
      if (t == 2'b10) m_in_pkt = 1'b0;
    end
  endfunction

  // Downstream ports: ack offered flits after a random delay, raise Tailpassed
  // some cycles after a tail, and watch grant/request consistency.
  initial begin
    int         dly [4];
    int         tpd [4];
    logic [3:0] prev_req;
    logic [1:0] t;
    for (int j = 0; j < 4; j++) begin
      dly[j] = 0;
      tpd[j] = -1;
    end
    prev_req = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        ack_dw_i = '0;
        for (int j = 0; j < 4; j++) begin
          dly[j] = 0;
          tpd[j] = -1;
        end
        prev_req = req_dw_o;
      end else begin
        if ($countones(PacketEnable_dw_o) > 1) mon_err++;
        for (int j = 0; j < 4; j++) begin
          if (req_dw_o[j] != prev_req[j] && !PacketEnable_dw_o[j]) mon_err++;
          if (PacketEnable_dw_o[j]) pe_hits[j]++;
          if (tpd[j] > 0) tpd[j]--;
          else if (tpd[j] == 0) begin
            tp_resp[j] = 1'b1;
            tpd[j] = -1;
          end
          if (ack_en && req_dw_o[j] != ack_dw_i[j]) begin
            if (dly[j] > 0) dly[j]--;
            else begin
              rx_q[j].push_back(data_dw[j]);
              ack_dw_i[j] = req_dw_o[j];
              dly[j] = $urandom_range(max_dly, 0);
              t = data_dw[j][1:0];
              if (t == 2'b10) tpd[j] = $urandom_range(3, 0);
              if (t == 2'b01 && tp_clear) tp_resp[j] = 1'b0;
            end
          end
        end
        prev_req = req_dw_o;
      end
    end
  end

  task automatic send_flit(input logic [W-1:0] d, input int hold);
    int n;
    @(negedge clk);
    Data_up_i = d;
    req_up_i  = ~req_up_i;
    if (hold > 0) begin
      gen_enable = 1'b0;
      repeat (hold) @(negedge clk);
      gen_enable = 1'b1;
    end
    n = 0;
    while (ack_up_o !== req_up_i && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ack_up_o !== req_up_i) begin
      errors++;
      $display("FAIL upstream_ack flit=%h: ack_up_o=%b required %b", d, ack_up_o, req_up_i);
    end
    model_flit(d);
  endtask

  function automatic logic [3:0] pe_mask();
    logic [3:0] m;
    m = '0;
    for (int j = 0; j < 4; j++) if (pe_hits[j] != pe_base[j]) m[j] = 1'b1;
    return m;
  endfunction

  task automatic open_window();
    for (int j = 0; j < 4; j++) pe_base[j] = pe_hits[j];
  endtask

  // Wait for all modelled flits to arrive and the grant to drop, then compare
  task automatic check_delivery(input string name);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
      done = (PacketEnable_dw_o === 4'b0000) && (ack_up_o === req_up_i);
      for (int j = 0; j < 4; j++) if (rx_q[j].size() < exp_q[j].size()) done = 1'b0;
    end
    checks++;
    if (PacketEnable_dw_o !== 4'b0000) begin
      errors++;
      $display("FAIL %s_grant_release: PacketEnable_dw_o=%b required 0000", name, PacketEnable_dw_o);
    end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (rx_q[j].size() != exp_q[j].size()) begin
        errors++;
        $display("FAIL %s_count port%0d: got %0d flits required %0d", name, j, rx_q[j].size(), exp_q[j].size());
      end
      for (int i = chk_base[j]; i < exp_q[j].size(); i++) begin
        checks++;
        if (i >= rx_q[j].size()) begin
          errors++;
          $display("FAIL %s_flit port%0d[%0d]: missing, required %h", name, j, i, exp_q[j][i]);
        end else if (rx_q[j][i] !== exp_q[j][i]) begin
          errors++;
          $display("FAIL %s_flit port%0d[%0d]: got %h required %h", name, j, i, rx_q[j][i], exp_q[j][i]);
        end
      end
      chk_base[j] = exp_q[j].size();
    end
    checks++;
    if (mon_err != mon_base) begin
      errors++;
      $display("FAIL %s_protocol: %0d grant/onehot violations required 0", name, mon_err - mon_base);
    end
    mon_base = mon_err;
  endtask

  task automatic check_mask(input string name, input logic [3:0] want);
    checks++;
    if (pe_mask() !== want) begin
      errors++;
      $display("FAIL %s_ports: granted ports %b required %b", name, pe_mask(), want);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if (ack_up_o !== 1'b0 || req_dw_o !== 4'b0 || PacketEnable_dw_o !== 4'b0) begin
      errors++;
      $display("FAIL %s_ctrl: ack=%b req=%b pe=%b required 0/0000/0000", name, ack_up_o, req_dw_o, PacketEnable_dw_o);
    end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (data_dw[j] !== '0) begin
        errors++;
        $display("FAIL %s_data%0d: got %h required 0", name, j, data_dw[j]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tp_force = 4'hF;
    repeat (20) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (PacketEnable_dw_o !== 4'b0 || req_dw_o !== 4'b0) begin
      errors++;
      $display("FAIL reset_tailpassed_ignored: pe=%b req=%b required 0000/0000", PacketEnable_dw_o, req_dw_o);
    end
    tp_force = 4'h0;
  endtask

  task automatic test_single_packet();
    open_window();
    tp_clear = 1'b1;
    send_flit(32'h0000_0001, 0);
    send_flit(32'h0000_0000, 0);
    send_flit(32'hFFFF_FFFC, 0);
    send_flit(32'h0000_0002, 0);
    check_delivery("single");
    check_mask("single", 4'b0001);
  endtask

  task automatic test_back_to_back();
    open_window();
    tp_clear = 1'b0;
    for (int k = 0; k < 2; k++) begin
      send_flit(32'h0000_0001, 0);
      send_flit(32'h0000_0000, 0);
      send_flit(32'hFFFF_FFFC, 0);
      send_flit(32'h0000_0002, 0);
    end
    check_delivery("back_to_back");
    check_mask("back_to_back", 4'b0001);
    tp_clear = 1'b1;
  endtask

  task automatic test_loc3();
    logic [3:0] rq;
    open_window();
    rq = req_dw_o;
    send_flit(32'h0000_000D, 0);
    send_flit(32'h1234_5670, 0);
    send_flit(32'hABCD_EF02, 0);
    check_delivery("loc3");
    check_mask("loc3", 4'b1000);
    checks++;
    if (req_dw_o[2:0] !== rq[2:0]) begin
      errors++;
      $display("FAIL loc3_other_req: req_dw_o[2:0]=%b required %b", req_dw_o[2:0], rq[2:0]);
    end
  endtask

  task automatic test_drop_in_idle();
    logic [3:0] rq;
    open_window();
    rq = req_dw_o;
    send_flit(32'h0000_0000, 0);
    send_flit(32'h0000_0003, 0);
    repeat (4) @(negedge clk);
    checks++;
    if (req_dw_o !== rq || PacketEnable_dw_o !== 4'b0) begin
      errors++;
      $display("FAIL drop_no_forward: req=%b pe=%b required %b/0000", req_dw_o, PacketEnable_dw_o, rq);
    end
    send_flit(32'h0000_0009, 0);
    send_flit(32'h0000_0006, 0);
    check_delivery("drop");
    check_mask("drop", 4'b0100);
  endtask

  task automatic test_gen_enable();
    open_window();
    @(negedge clk);
    gen_enable = 1'b0;
    Data_up_i  = 32'h0000_0005;
    req_up_i   = ~req_up_i;
    repeat (5) @(negedge clk);
    checks++;
    if (ack_up_o === req_up_i) begin
      errors++;
      $display("FAIL gen_enable_hold: ack_up_o=%b required %b", ack_up_o, ~req_up_i);
    end
    gen_enable = 1'b1;
    @(negedge clk);
    checks++;
    if (ack_up_o !== req_up_i) begin
      errors++;
      $display("FAIL gen_enable_release: ack_up_o=%b required %b", ack_up_o, req_up_i);
    end
    model_flit(32'h0000_0005);
    send_flit(32'hFFFF_0002, 0);
    check_delivery("gen_enable");
    check_mask("gen_enable", 4'b0010);
  endtask

  task automatic test_reset_abort();
    logic [3:0] rq;
    ack_en = 1'b0;
    rq = req_dw_o;
    @(negedge clk);
    Data_up_i = 32'h0000_0005;
    req_up_i  = ~req_up_i;
    repeat (4) @(negedge clk);
    checks++;
    if (PacketEnable_dw_o !== 4'b0010 || req_dw_o !== (rq ^ 4'b0010)) begin
      errors++;
      $display("FAIL abort_pending: pe=%b req=%b required 0010/%b", PacketEnable_dw_o, req_dw_o, rq ^ 4'b0010);
    end
    reset = 1'b1;
    req_up_i = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("abort");
    reset = 1'b0;
    ack_en = 1'b1;
    m_in_pkt = 1'b0;
    open_window();
    send_flit(32'h0000_0005, 0);
    send_flit(32'h0000_0042, 0);
    check_delivery("abort_recover");
    check_mask("abort_recover", 4'b0010);
  endtask

  task automatic test_random();
    logic [W-1:0] d;
    int           nb;
    int           hold;
    for (int p = 0; p < 40; p++) begin
      max_dly  = $urandom_range(3, 0);
      tp_clear = $urandom_range(1, 0) == 1;
      if ($urandom_range(3, 0) == 0) begin
        d = $urandom;
        if (d[1:0] == 2'b01) d[1:0] = 2'b11;
        send_flit(d, 0);
      end
      d = $urandom;
      d[1:0] = 2'b01;
      hold = ($urandom_range(7, 0) == 0) ? $urandom_range(4, 1) : 0;
      send_flit(d, hold);
      nb = $urandom_range(4, 0);
      for (int b = 0; b < nb; b++) begin
        d = $urandom;
        if (d[1:0] == 2'b10) d[1:0] = 2'b00;
        hold = ($urandom_range(7, 0) == 0) ? $urandom_range(4, 1) : 0;
        send_flit(d, hold);
      end
      d = $urandom;
      d[1:0] = 2'b10;
      send_flit(d, 0);
    end
    check_delivery("random");
    max_dly  = 0;
    tp_clear = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_loc3();
    test_drop_in_idle();
    test_gen_enable();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
